fifo_wr_arbiter: RTL



---
 rtl/fifo_arb_pkg.sv | 48 ++++
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/rr_pick_comb.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its
// round-robin picker.
package fifo_arb_pkg;

    // Arbiter FSM states: waiting for a request, or streaming one burst.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Ceiling log2; used for index and counter widths (clog2(1) = 0).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Round-robin pick over up to eight requesters: returns the first set
    // bit of req scanning last+1, last+2, ... modulo n. When no bit is set
    // the result is last; callers qualify it with |req.
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input int         n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = (int'(last) + k) % n;
            if ((k <= n) && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake plus FIFO write-port signals of the arbiter.
// The arbiter uses the master modport; the requesters/FIFO side uses slave.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    import fifo_arb_pkg::*;

    localparam int ID_W = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        in_ready;
    logic                      w_full;
    logic                      w_en;
    logic [DATA_W-1:0]         w_data;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;

    modport master (
        input  in_valid, in_data, w_full,
        output in_ready, w_en, w_data, grant_id, busy
    );

    modport slave (
        output in_valid, in_data, w_full,
        input  in_ready, w_en, w_data, grant_id, busy
    );

endinterface

// File: rtl/rr_pick_comb.sv
// Combinational round-robin priority picker, NUM_REQ (2..8) wide.
// pick is the first requester after 'last' in circular order; any flags
// that pick is meaningful.
module rr_pick_comb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    pick,
    output logic               any
);

    logic [7:0] req_ext_s;
    logic [2:0] last_ext_s;
    logic [2:0] pick_ext_s;
    logic       unused_pick_hi_s;

    // Widen to the eight-requester helper and pick the next grantee.
    always_comb begin
        req_ext_s                 = 8'd0;
        req_ext_s[NUM_REQ-1:0]    = req;
        last_ext_s                = 3'd0;
        last_ext_s[ID_W-1:0]      = last;
        pick_ext_s                = rr_pick(req_ext_s, last_ext_s, NUM_REQ);
    end

    assign pick             = pick_ext_s[ID_W-1:0];
    assign any              = |req;
    assign unused_pick_hi_s = ^pick_ext_s;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NUM_REQ producers. Grants are
// round-robin and last for one burst: up to BURST_LEN accepted words, or
// until GAP_MAX consecutive idle (valid-low, not-full) cycles. A full FIFO
// stalls the burst without ending it. Handshake outputs are combinational
// so the FIFO write lands on the same edge as the requester handshake.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 16,
    parameter int GAP_MAX   = 3
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.master  bus
);

    localparam int ID_W   = clog2(NUM_REQ);
    localparam int BCNT_W = clog2(BURST_LEN + 1);

    localparam logic [BCNT_W-1:0] BCNT_LAST  = BCNT_W'(BURST_LEN - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE   = BCNT_W'(1);
    localparam logic [3:0]        GAP_LAST   = 4'(GAP_MAX - 1);
    localparam logic [ID_W-1:0]   LAST_RESET = ID_W'(NUM_REQ - 1);

    arb_state_e        state_r, state_s;
    logic [ID_W-1:0]   grant_id_r, grant_id_s;
    logic [ID_W-1:0]   last_grant_r, last_grant_s;
    logic [ID_W-1:0]   pick_s;
    logic              any_req_s;
    logic [BCNT_W-1:0] bcnt_r, bcnt_s;
    logic [3:0]        gcnt_r, gcnt_s;
    logic              burst_end_s;

    logic [NUM_REQ-1:0] in_ready_s;
    logic               w_en_s;
    logic [DATA_W-1:0]  w_data_s;
    logic               grant_valid_s;

    rr_pick_comb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req  (bus.in_valid),
        .last (last_grant_r),
        .pick (pick_s),
        .any  (any_req_s)
    );

    // Zero-latency handshake: only the grantee sees ready, and only while
    // the FIFO has room; write data always follows the grantee's slice.
    always_comb begin
        in_ready_s    = '0;
        w_en_s        = 1'b0;
        grant_valid_s = bus.in_valid[grant_id_r];
        w_data_s      = bus.in_data[grant_id_r*DATA_W +: DATA_W];
        if (state_r == BURST) begin
            in_ready_s[grant_id_r] = ~bus.w_full;
            w_en_s                 = grant_valid_s & ~bus.w_full;
        end else begin
            in_ready_s = '0;
            w_en_s     = 1'b0;
        end
    end

    // Next state: grant selection in IDLE, word/gap counting and burst
    // termination in BURST. A full FIFO freezes both counters.
    always_comb begin
        state_s      = state_r;
        grant_id_s   = grant_id_r;
        last_grant_s = last_grant_r;
        bcnt_s       = bcnt_r;
        gcnt_s       = gcnt_r;
        burst_end_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s    = BURST;
                    grant_id_s = pick_s;
                    bcnt_s     = '0;
                    gcnt_s     = 4'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                if (w_en_s) begin
                    bcnt_s      = bcnt_r + BCNT_ONE;
                    gcnt_s      = 4'd0;
                    burst_end_s = (bcnt_r == BCNT_LAST);
                end else if (!bus.w_full) begin
                    gcnt_s      = gcnt_r + 4'd1;
                    burst_end_s = (gcnt_r == GAP_LAST);
                end else begin
                    bcnt_s = bcnt_r;
                    gcnt_s = gcnt_r;
                end
                if (burst_end_s) begin
                    state_s      = IDLE;
                    last_grant_s = grant_id_r;
                end else begin
                    state_s = BURST;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, grant and counter registers; reset aborts any burst at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            grant_id_r   <= '0;
            last_grant_r <= LAST_RESET;
            bcnt_r       <= '0;
            gcnt_r       <= 4'd0;
        end else begin
            state_r      <= state_s;
            grant_id_r   <= grant_id_s;
            last_grant_r <= last_grant_s;
            bcnt_r       <= bcnt_s;
            gcnt_r       <= gcnt_s;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.w_en     = w_en_s;
    assign bus.w_data   = w_data_s;
    assign bus.grant_id = grant_id_r;
    assign bus.busy     = (state_r == BURST);

endmodule
